// File: rtl/hex_scroll_pkg.sv
// Shared definitions for the scrolling seven-segment message display:
// FSM state encoding, the blank segment pattern and the character glyph table.
package hex_scroll_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int GLYPH_COUNT = 16;

  // Hexadecimal glyphs 0..F; codes beyond the table show blank
  localparam logic [6:0] GLYPH_TABLE [GLYPH_COUNT] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_scroll_display_char_seg_decoder.sv
// Combinational character-code to active-low seven-segment decoder.
// Codes without a glyph table entry decode to blank.
module char_seg_decoder
  import hex_scroll_pkg::*;
#(
  parameter int CHAR_W = 3
) (
  input  logic [CHAR_W-1:0] code,
  output logic [6:0]        seg
);

  // Look the code up in the glyph table, defaulting to blank
  always_comb begin
    seg = SEG_BLANK;
    for (int i = 0; i < GLYPH_COUNT; i++) begin
      if ((i < (2 ** CHAR_W)) && (code == CHAR_W'(i))) begin
        seg = GLYPH_TABLE[i];
      end
    end
  end

endmodule

// File: rtl/hex_scroll_display.sv
// Scrolling message display: a writable MSG_LEN-character message is shown
// through a NUM_DIGITS-wide window on active-low seven-segment digits.
// The window start auto-scrolls on a prescaled tick (either direction) or is
// loaded directly. Optional digit blinking is enabled by HEX_SCROLL_BLINK_EN.
module hex_scroll_display
  import hex_scroll_pkg::*;
#(
  parameter  int NUM_DIGITS = 8,
  parameter  int MSG_LEN    = 8,
  parameter  int CHAR_W     = 3,
  parameter  int PRESCALE   = 50000000,
  localparam int OW         = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    dir,
  input  logic                    load_offset,
`ifdef HEX_SCROLL_BLINK_EN
  input  logic                    blink,
`endif
  input  logic [OW-1:0]           offset_in,
  input  logic                    wr_en,
  input  logic [OW-1:0]           wr_addr,
  input  logic [CHAR_W-1:0]       wr_data,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic [OW-1:0]           offset,
  output logic                    running,
  output logic                    wrap
);

  localparam int PW = $clog2(PRESCALE);

  state_t                  state_q;
  state_t                  state_d;
  logic [PW-1:0]           presc_q;
  logic [PW-1:0]           presc_d;
  logic [OW-1:0]           offset_q;
  logic [OW-1:0]           offset_d;
  logic                    wrap_q;
  logic                    wrap_d;
  logic                    tick;
  logic                    blank_all;
  logic [CHAR_W-1:0]       msg [MSG_LEN];
  logic [7*NUM_DIGITS-1:0] seg_q;
  logic [7*NUM_DIGITS-1:0] seg_d;

  // Message index shown on digit d for a given window start
  function automatic logic [OW-1:0] window_index(input logic [OW-1:0] off, input int d);
    return OW'((int'(off) + NUM_DIGITS - 1 - d) % MSG_LEN);
  endfunction

  // Run/idle state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: stop dominates start when both are asserted
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && !stop) state_d = ST_RUN;
      ST_RUN:  if (stop)           state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Tick generation, offset stepping with wrap detection, prescaler advance
  always_comb begin
    tick     = (state_q == ST_RUN) && (presc_q == PW'(PRESCALE - 1));
    offset_d = offset_q;
    wrap_d   = 1'b0;
    presc_d  = '0;
    if (load_offset) begin
      offset_d = (int'(offset_in) >= MSG_LEN) ? '0 : offset_in;
    end else if (tick) begin
      if (!dir) begin
        if (offset_q == OW'(MSG_LEN - 1)) begin
          offset_d = '0;
          wrap_d   = 1'b1;
        end else begin
          offset_d = offset_q + OW'(1);
        end
      end else begin
        if (offset_q == '0) begin
          offset_d = OW'(MSG_LEN - 1);
          wrap_d   = 1'b1;
        end else begin
          offset_d = offset_q - OW'(1);
        end
      end
    end
    if ((state_q == ST_RUN) && (state_d == ST_RUN) && !load_offset && !tick) begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Offset, prescaler and wrap pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_q <= '0;
      presc_q  <= '0;
      wrap_q   <= 1'b0;
    end else begin
      offset_q <= offset_d;
      presc_q  <= presc_d;
      wrap_q   <= wrap_d;
    end
  end

  // Message storage: reset to an ascending code pattern, out-of-range writes dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MSG_LEN; k++) begin
        msg[k] <= CHAR_W'(k);
      end
    end else if (wr_en && (int'(wr_addr) < MSG_LEN)) begin
      msg[wr_addr] <= wr_data;
    end
  end

`ifdef HEX_SCROLL_BLINK_EN
  logic blink_phase_q;

  // Blink phase flips on each scroll tick while running, parked low when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_phase_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      blink_phase_q <= 1'b0;
    end else if (tick) begin
      blink_phase_q <= ~blink_phase_q;
    end
  end

  assign blank_all = blink && blink_phase_q;
`else
  assign blank_all = 1'b0;
`endif

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    logic [OW-1:0]     idx;
    logic [CHAR_W-1:0] code;
    logic [6:0]        glyph;

    assign idx  = window_index(offset_q, d);
    assign code = msg[idx];

    char_seg_decoder #(
      .CHAR_W(CHAR_W)
    ) u_dec (
      .code(code),
      .seg (glyph)
    );

    assign seg_d[7*d +: 7] = blank_all ? SEG_BLANK : glyph;
  end

  // Registered segment outputs, blank while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '1;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg     = seg_q;
  assign offset  = offset_q;
  assign wrap    = wrap_q;
  assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_hex_scroll_display.sv
// Self-checking bench for hex_scroll_display with a behavioural model of the
// scrolling window, message memory and tick timing.
module tb_hex_scroll_display;

  localparam int ND = 8;
  localparam int ML = 8;
  localparam int CW = 3;
  localparam int PS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, dir, load_offset, wr_en;
  logic [2:0]  offset_in, wr_addr, wr_data;
  logic [55:0] seg;
  logic [2:0]  offset;
  logic        running, wrap;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_msg [ML];
  int          m_off;
  bit          m_run;
  int          m_cnt;
  bit          m_wrap;
  logic [55:0] m_seg;

  always #5 clk = ~clk;

  hex_scroll_display #(
    .NUM_DIGITS(ND),
    .MSG_LEN   (ML),
    .CHAR_W    (CW),
    .PRESCALE  (PS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .dir        (dir),
    .load_offset(load_offset),
`ifdef HEX_SCROLL_BLINK_EN
    .blink      (1'b0),
`endif
    .offset_in  (offset_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .seg        (seg),
    .offset     (offset),
    .running    (running),
    .wrap       (wrap)
  );

  // Hex glyphs written out from the display's character set
  function automatic logic [6:0] glyph(input int c);
    case (c)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      default: return 7'h7F;
    endcase
  endfunction

  // Leftmost digit shows msg[off], indices increase to the right with wraparound
  function automatic logic [55:0] window_of(input int off);
    logic [55:0] r;
    for (int p = 0; p < ND; p++) begin
      r[7*(ND-1-p) +: 7] = glyph(m_msg[(off + p) % ML]);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ML; k++) m_msg[k] = k;
    m_off  = 0;
    m_run  = 0;
    m_cnt  = 0;
    m_wrap = 0;
    m_seg  = '1;
  endtask

  // One clock edge of the model: m_cnt is cycles spent running since the last tick/load
  task automatic model_edge();
    bit tick;
    bit next_run;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick   = m_run && (m_cnt == PS - 1);
    m_seg  = window_of(m_off);
    m_wrap = 0;
    if (load_offset) begin
      m_off = (int'(offset_in) >= ML) ? 0 : int'(offset_in);
    end else if (tick) begin
      if (!dir) begin
        m_wrap = (m_off == ML - 1);
        m_off  = (m_off + 1) % ML;
      end else begin
        m_wrap = (m_off == 0);
        m_off  = (m_off + ML - 1) % ML;
      end
    end
    next_run = stop ? 1'b0 : (start ? 1'b1 : m_run);
    if (m_run && next_run && !load_offset && !tick) m_cnt++;
    else m_cnt = 0;
    m_run = next_run;
    if (wr_en && int'(wr_addr) < ML) m_msg[wr_addr] = int'(wr_data);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic st, input logic d, input logic ld,
                               input logic [2:0] oi, input logic we, input logic [2:0] wa,
                               input logic [2:0] wd);
    start       = s;
    stop        = st;
    dir         = d;
    load_offset = ld;
    offset_in   = oi;
    wr_en       = we;
    wr_addr     = wa;
    wr_data     = wd;
  endtask

  task automatic test_reset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    step();
    step();
    checks++; if (seg !== '1) begin errors++; $display("[TB] FAIL reset_seg: got %h expected all ones", seg); end
    checks++; if (offset !== 3'd0) begin errors++; $display("[TB] FAIL reset_offset: got %0d expected 0", offset); end
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL reset_running: got %b expected 0", running); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap: got %b expected 0", wrap); end
    rst_n = 1'b1;
    step();
    checks++; if (seg !== m_seg) begin errors++; $display("[TB] FAIL release_seg: got %h expected %h", seg, m_seg); end
    checks++; if (seg[55:49] !== 7'h40) begin errors++; $display("[TB] FAIL release_digit7: got %h expected 40", seg[55:49]); end
    checks++; if (seg[6:0] !== 7'h78) begin errors++; $display("[TB] FAIL release_digit0: got %h expected 78", seg[6:0]); end
  endtask

  task automatic test_scroll_up();
    int wraps = 0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 33; i++) begin
      step();
      if (wrap === 1'b1) wraps++;
      checks++; if (offset !== 3'(m_off)) begin errors++; $display("[TB] FAIL up_offset: got %0d expected %0d", offset, m_off); end
      checks++; if (wrap !== m_wrap) begin errors++; $display("[TB] FAIL up_wrap: got %b expected %b", wrap, m_wrap); end
      checks++; if (seg !== m_seg) begin errors++; $display("[TB] FAIL up_seg: got %h expected %h", seg, m_seg); end
    end
    checks++; if (wraps != 1) begin errors++; $display("[TB] FAIL up_wrap_count: got %0d expected 1", wraps); end
    checks++; if (offset !== 3'd0) begin errors++; $display("[TB] FAIL up_final_offset: got %0d expected 0", offset); end
    checks++; if (running !== 1'b1) begin errors++; $display("[TB] FAIL up_running: got %b expected 1", running); end
  endtask

  task automatic test_scroll_down();
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
    step();
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (offset !== 3'(m_off)) begin errors++; $display("[TB] FAIL down_offset: got %0d expected %0d", offset, m_off); end
    end
    checks++; if (offset !== 3'd7) begin errors++; $display("[TB] FAIL down_first_tick: got %0d expected 7", offset); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("[TB] FAIL down_wrap: got %b expected 1", wrap); end
    step();
    checks++; if (seg[55:49] !== glyph(m_msg[7])) begin errors++; $display("[TB] FAIL down_digit7: got %h expected %h", seg[55:49], glyph(m_msg[7])); end
    checks++; if (seg[48:42] !== glyph(m_msg[0])) begin errors++; $display("[TB] FAIL down_digit6: got %h expected %h", seg[48:42], glyph(m_msg[0])); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("[TB] FAIL down_wrap_width: got %b expected 0", wrap); end
  endtask

  task automatic test_load_on_tick();
    int n = 0;
    int guard = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    while (!(m_run && m_cnt == PS - 1) && guard < 8) begin
      step();
      guard++;
    end
    checks++; if (guard >= 8) begin errors++; $display("[TB] FAIL load_tick_align: got no tick within %0d cycles", guard); end
    applyStimulus(0, 0, 0, 1, 3'd5, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (offset !== 3'd5) begin errors++; $display("[TB] FAIL load_offset: got %0d expected 5", offset); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("[TB] FAIL load_wrap: got %b expected 0", wrap); end
    while (offset === 3'd5 && n < 10) begin
      step();
      n++;
    end
    checks++; if (n != 4) begin errors++; $display("[TB] FAIL load_next_tick: got %0d cycles expected 4", n); end
    checks++; if (offset !== 3'd6) begin errors++; $display("[TB] FAIL load_next_offset: got %0d expected 6", offset); end
  endtask

  task automatic test_start_stop_and_write();
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
    step();
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    step();
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL collide_running: got %b expected 0", running); end
    applyStimulus(0, 0, 0, 0, 0, 1, 3'd3, 3'd6);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL collide_stays_idle: got %b expected 0", running); end
    step();
    checks++; if (seg[34:28] !== 7'h02) begin errors++; $display("[TB] FAIL write_digit4: got %h expected 02", seg[34:28]); end
    checks++; if (seg !== m_seg) begin errors++; $display("[TB] FAIL write_seg: got %h expected %h", seg, m_seg); end
  endtask

  task automatic test_async_reset();
    applyStimulus(1, 0, 0, 1, 3'd5, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    checks++; if (offset !== 3'd5 || running !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset: got offset %0d running %b expected 5 1", offset, running); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (seg !== '1) begin errors++; $display("[TB] FAIL async_seg: got %h expected all ones", seg); end
    checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL async_running: got %b expected 0", running); end
    checks++; if (offset !== 3'd0) begin errors++; $display("[TB] FAIL async_offset: got %0d expected 0", offset); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (seg !== m_seg) begin errors++; $display("[TB] FAIL async_release_seg: got %h expected %h", seg, m_seg); end
    checks++; if (seg[34:28] !== 7'h30) begin errors++; $display("[TB] FAIL async_msg_restore: got %h expected 30", seg[34:28]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                    ($urandom_range(0, 29) == 0) ? ~dir : dir,
                    $urandom_range(0, 24) == 0, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)));
      step();
      checks++; if (offset !== 3'(m_off)) begin errors++; $display("[TB] FAIL rand_offset: got %0d expected %0d", offset, m_off); end
      checks++; if (running !== m_run) begin errors++; $display("[TB] FAIL rand_running: got %b expected %b", running, m_run); end
      checks++; if (wrap !== m_wrap) begin errors++; $display("[TB] FAIL rand_wrap: got %b expected %b", wrap, m_wrap); end
      checks++; if (seg !== m_seg) begin errors++; $display("[TB] FAIL rand_seg: got %h expected %h", seg, m_seg); end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_scroll_up();
    test_scroll_down();
    test_load_on_tick();
    test_start_stop_and_write();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_scroll_display.md
Name: hex_scroll_display

Overview:
- Parametrised successor to the eight-digit sliding-window character display.
- Holds a writable message of MSG_LEN character codes and shows a NUM_DIGITS-wide window of it on active-low seven-segment digits.
- Window start (offset) either auto-scrolls on a prescaled tick, in either direction, or is loaded directly.
- Sits between board switches/keys (or a CPU write port) and the HEX display pins.

Parameters:
NUM_DIGITS, 8, number of seven-segment digits driven
MSG_LEN, 8, message length in characters (>= NUM_DIGITS not required; window wraps)
CHAR_W, 3, width of one character code
PRESCALE, 50000000, clk cycles per scroll tick (>= 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level/pulse; enter RUN
stop  in  1  level/pulse; enter IDLE, hold offset
dir  in  1  0 = offset increments per tick, 1 = decrements
load_offset  in  1  load offset_in this cycle
offset_in  in  OW=$clog2(MSG_LEN)  new window start
wr_en  in  1  write one message character
wr_addr  in  OW  message index
wr_data  in  CHAR_W  character code
seg  out  7*NUM_DIGITS  digit d at seg[7d+6:7d], active low, digit NUM_DIGITS-1 leftmost
offset  out  OW  current window start
running  out  1  high in RUN
wrap  out  1  one-cycle pulse when offset wraps

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low. Reset takes effect immediately, mid-operation included.
- Reset values:
  - state IDLE, offset 0, prescaler 0, running 0, wrap 0.
  - seg all ones (blank).
  - msg[k] = k mod 2^CHAR_W.
- Window mapping: digit d shows glyph(msg[(offset + NUM_DIGITS-1-d) mod MSG_LEN]). The leftmost digit shows msg[offset]; indices increase to the right.
- Latency: seg is registered. It reflects any offset or message change exactly 1 cycle after that register updates.
- Glyphs: codes index the glyph table in the package. Codes with no table entry display blank (7'h7F).
- States:
  - IDLE: prescaler held at 0, offset static.
  - IDLE -> RUN on start. Prescaler clears on entry.
  - RUN: prescaler counts 0..PRESCALE-1. tick = (prescaler == PRESCALE-1); prescaler then returns to 0.
  - RUN -> IDLE on stop. Offset retained.
  - start and stop in the same cycle: stop wins.
- Tick in RUN:
  - dir=0: offset = (offset==MSG_LEN-1) ? 0 : offset+1.
  - dir=1: offset = (offset==0) ? MSG_LEN-1 : offset-1.
  - wrap pulses in the cycle after a wrap transition (registered, 1 cycle wide).
- load_offset: highest priority over tick, in any state.
  - offset <= offset_in; if offset_in >= MSG_LEN, offset <= 0.
  - Prescaler clears.
  - No wrap pulse.
- Message writes: wr_en writes msg[wr_addr] <= wr_data. Writes with wr_addr >= MSG_LEN are ignored. A write coinciding with a tick or load is applied in the same edge; the display shows the new character 1 cycle later.
- dir change mid-RUN: takes effect on the next tick; prescaler is not disturbed.

Optional Feature:
- Macro: HEX_SCROLL_BLINK_EN.
- Defined:
  - Adds input blink (1 bit) and an internal blink_phase register (reset 0).
  - blink_phase toggles on every prescaler wrap while in RUN; in IDLE it is forced to 0.
  - While blink=1 and blink_phase=1, all digits are blank (same 1-cycle registered latency).
- Undefined: no blink port, no blanking logic.

Decomposition:
- Package hex_scroll_pkg holds:
  - state encoding (ST_IDLE, ST_RUN)
  - SEG_BLANK = 7'h7F
  - the glyph constant table for codes 0..2^CHAR_W-1
- Sub-module char_seg_decoder: combinational CHAR_W code -> 7-bit active-low segments, using the package table. Instantiated NUM_DIGITS times via generate.

Test Plan:
All scenarios use NUM_DIGITS=8, MSG_LEN=8, CHAR_W=3, PRESCALE=4.
1. Reset, then release -> seg all ones during reset; 1 cycle after release digit 7..0 show glyph(0)..glyph(7); offset=0, running=0.
2. Pulse start with dir=0 -> offset 1,2,...,7,0 every 4 cycles; wrap high for exactly 1 cycle, after the 7->0 step; after 32 cycles offset=0 again.
3. start with dir=1 from offset 0 -> first tick gives offset 7 and a wrap pulse; next cycle digit 7 = glyph(msg[7]), digit 6 = glyph(msg[0]).
4. load_offset=1, offset_in=5 in the same cycle as a tick -> offset=5 (no increment, no wrap); next change 4 cycles later, to 6.
5. start and stop together -> stays IDLE, running=0. Then wr_en, wr_addr=3, wr_data=6 at offset 0 -> digit 4 shows glyph(6) one cycle after the write.
6. Drop rst_n asynchronously mid-RUN at offset 5 -> immediately seg all ones, running=0, offset=0, msg restored to 0..7.
